// File: rtl/mmp_iddmm_pkg.sv
// Shared constants, FSM state encodings and the latency helper for the runtime-length
// word-serial Montgomery multiplier.
package mmp_iddmm_pkg;

    localparam int unsigned KDefault    = 128;
    localparam int unsigned NMaxDefault = 32;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StMul   = 3'd1;
    localparam logic [2:0] StMtop  = 3'd2;
    localparam logic [2:0] StQcalc = 3'd3;
    localparam logic [2:0] StRed   = 3'd4;
    localparam logic [2:0] StRtop  = 3'd5;
    localparam logic [2:0] StSub   = 3'd6;
    localparam logic [2:0] StOut   = 3'd7;

    // Cycles from the accepted-start edge to the first valid result word.
    function automatic int unsigned rt_lat(input int unsigned n);
        return n * (2 * n + 3) + n + 1;
    endfunction

endpackage

// File: rtl/mmp_iddmm_mac.sv
// Combinational multiply-accumulate a*b + c + d; the operand bounds keep the sum within 2K bits.
module mmp_iddmm_mac
    import mmp_iddmm_pkg::*;
#(
    parameter int unsigned K = KDefault
) (
    input  logic [K-1:0]   a_i,
    input  logic [K-1:0]   b_i,
    input  logic [K-1:0]   c_i,
    input  logic [K-1:0]   d_i,
    output logic [2*K-1:0] p_o
);

    logic [2*K-1:0] prod;

    assign prod = {{K{1'b0}}, a_i} * {{K{1'b0}}, b_i};
    assign p_o  = prod + {{K{1'b0}}, c_i} + {{K{1'b0}}, d_i};

endmodule

// File: rtl/mmp_iddmm_rt.sv
// Runtime-length CIOS Montgomery multiplier: res = x*y*2^(-K*n) mod m, streamed out LS word first.
module mmp_iddmm_rt
    import mmp_iddmm_pkg::*;
#(
    parameter int unsigned K      = KDefault,
    parameter int unsigned N_MAX  = NMaxDefault,
    parameter int unsigned ADDR_W = $clog2(N_MAX),
    parameter int unsigned LEN_W  = $clog2(N_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [K-1:0]      wr_x,
    input  logic [K-1:0]      wr_y,
    input  logic [K-1:0]      wr_m,
    input  logic [K-1:0]      m1,
    input  logic [LEN_W-1:0]  n_words,
    input  logic              start,
    output logic              busy,
    output logic              err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [K-1:0]      res_data,
    output logic              res_last
);

    localparam int unsigned TW = $clog2(N_MAX + 2);
    localparam logic [LEN_W-1:0] NMaxL = LEN_W'(N_MAX);

    logic [K-1:0] x_mem [N_MAX];
    logic [K-1:0] y_mem [N_MAX];
    logic [K-1:0] m_mem [N_MAX];
    logic [K-1:0] d_mem [N_MAX];
    logic [K-1:0] t_q [N_MAX+2];
    logic [K-1:0] t_d [N_MAX+2];

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [K-1:0]      m1_q, m1_d, q_q, q_d, c_q, c_d;
    logic              borrow_q, borrow_d;
    logic              res_valid_q, res_valid_d, res_last_q, res_last_d, err_q, err_d;
    logic [K-1:0]      res_data_q, res_data_d;

    logic [K-1:0]   mac_a, mac_b, mac_c, mac_d;
    logic [2*K-1:0] mac_p;
    logic [K-1:0]   mac_lo, mac_hi;
    logic [K:0]     diff;
    logic [TW-1:0]  jt, jt_m1, nt, nt_p1, nt_m1;
    logic           last_j, last_i, use_d, wr_in_range;

    mmp_iddmm_mac #(.K(K)) u_mac (
        .a_i(mac_a),
        .b_i(mac_b),
        .c_i(mac_c),
        .d_i(mac_d),
        .p_o(mac_p)
    );

    assign mac_lo = mac_p[K-1:0];
    assign mac_hi = mac_p[2*K-1:K];
    assign jt     = TW'(j_q);
    assign jt_m1  = jt - 1'b1;
    assign nt     = TW'(n_q);
    assign nt_p1  = nt + 1'b1;
    assign nt_m1  = nt - 1'b1;
    assign last_j = (jt == nt_m1);
    assign last_i = (TW'(i_q) == nt_m1);
    assign diff   = {1'b0, t_q[jt]} - {1'b0, m_mem[j_q]} - {{K{1'b0}}, borrow_q};
    // Subtracted value is kept when the top word overflowed or t >= m.
    assign use_d  = (t_q[nt] == K'(1)) || !borrow_q;
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(N_MAX));

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        n_d         = n_q;
        m1_d        = m1_q;
        q_d         = q_q;
        c_d         = c_q;
        borrow_d    = borrow_q;
        t_d         = t_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        err_d       = 1'b0;
        mac_a       = '0;
        mac_b       = '0;
        mac_c       = '0;
        mac_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (n_words == '0 || n_words > NMaxL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = StMul;
                        n_d      = n_words;
                        m1_d     = m1;
                        i_d      = '0;
                        j_d      = '0;
                        c_d      = '0;
                        borrow_d = 1'b0;
                        for (int k = 0; k < N_MAX + 2; k++) t_d[k] = '0;
                    end
                end
            end
            StMul: begin
                mac_a  = x_mem[j_q];
                mac_b  = y_mem[i_q];
                mac_c  = t_q[jt];
                mac_d  = (j_q == '0) ? '0 : c_q;
                t_d[jt] = mac_lo;
                c_d    = mac_hi;
                if (last_j) begin
                    state_d = StMtop;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StMtop: begin
                mac_c      = t_q[nt];
                mac_d      = c_q;
                t_d[nt]    = mac_lo;
                t_d[nt_p1] = mac_hi;
                state_d    = StQcalc;
            end
            StQcalc: begin
                mac_a   = t_q[0];
                mac_b   = m1_q;
                q_d     = mac_lo;
                j_d     = '0;
                state_d = StRed;
            end
            StRed: begin
                // Word 0 only yields a carry: t[0] + m[0]*q is zero mod 2^K by choice of q.
                mac_a = m_mem[j_q];
                mac_b = q_q;
                mac_c = t_q[jt];
                mac_d = (j_q == '0) ? '0 : c_q;
                c_d   = mac_hi;
                if (j_q != '0) t_d[jt_m1] = mac_lo;
                if (last_j) begin
                    state_d = StRtop;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StRtop: begin
                mac_c      = t_q[nt];
                mac_d      = c_q;
                t_d[nt_m1] = mac_lo;
                t_d[nt]    = t_q[nt_p1] + K'(mac_p[K]);
                t_d[nt_p1] = '0;
                j_d        = '0;
                if (last_i) begin
                    state_d  = StSub;
                    borrow_d = 1'b0;
                end else begin
                    state_d = StMul;
                    i_d     = i_q + 1'b1;
                end
            end
            StSub: begin
                borrow_d = diff[K];
                if (last_j) begin
                    state_d = StOut;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StOut: begin
                // j_q points at the next word to load; loading happens on the first cycle or on a take.
                if (res_valid_q && res_ready && res_last_q) begin
                    state_d     = StIdle;
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                end else if (!res_valid_q || res_ready) begin
                    res_valid_d = 1'b1;
                    res_data_d  = use_d ? d_mem[j_q] : t_q[jt];
                    res_last_d  = last_j;
                    j_d         = j_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            n_q         <= '0;
            m1_q        <= '0;
            q_q         <= '0;
            c_q         <= '0;
            borrow_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            n_q         <= n_d;
            m1_q        <= m1_d;
            q_q         <= q_d;
            c_q         <= c_d;
            borrow_q    <= borrow_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        t_q <= t_d;
        if (wr_ena[0] && wr_in_range) x_mem[wr_addr] <= wr_x;
        if (wr_ena[1] && wr_in_range) y_mem[wr_addr] <= wr_y;
        if (wr_ena[2] && wr_in_range) m_mem[wr_addr] <= wr_m;
        if (state_q == StSub) d_mem[j_q] <= diff[K-1:0];
    end

    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule

// File: tb/tb_mmp_iddmm_rt.sv
// Randomised self-checking bench for mmp_iddmm_rt (K=8, N_MAX=4) against a modular-arithmetic model.
module tb_mmp_iddmm_rt;

    localparam int unsigned K      = 8;
    localparam int unsigned N_MAX  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 3;
    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [K-1:0]      wr_x, wr_y, wr_m, m1;
    logic [LEN_W-1:0]  n_words;
    logic              start, busy, err, res_valid, res_ready, res_last;
    logic [K-1:0]      res_data;

    mmp_iddmm_rt #(.K(K), .N_MAX(N_MAX), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .wr_m(wr_m), .m1(m1), .n_words(n_words), .start(start), .busy(busy), .err(err),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
    );

    always #HALF clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [K-1:0] exp_q[$];
    bit           exp_last_q[$];
    bit           wait_first = 0;
    bit           exp_idle = 0;
    bit           ready_full = 1;
    int           exp_lat = 0;
    longint       t_acc = 0;
    bit           pv = 0, pr = 0;
    logic [K-1:0] pd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // x*y*2^(-8n) mod m by reducing the product then halving modulo odd m 8n times.
    function automatic logic [31:0] mont_ref(input int n, input logic [31:0] x, y, m);
        longint unsigned v, lm;
        lm = 64'(m);
        v  = (64'(x) * 64'(y)) % lm;
        for (int i = 0; i < 8 * n; i++) v = v[0] ? (v + lm) >> 1 : v >> 1;
        return v[31:0];
    endfunction

    function automatic logic [7:0] calc_m1(input logic [7:0] m0);
        for (int v = 0; v < 256; v++) begin
            if (((int'(m0) * v) & 255) == 255) return 8'(v);
        end
        return 8'h00;
    endfunction

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = ready_full ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    // Compare process: result words, last flags, stall stability, first-word latency, busy release.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr) begin
                chk("stall_valid", 32'(res_valid), 32'd1);
                chk("stall_data", 32'(res_data), 32'(pd));
            end
            if (exp_idle) begin
                chk("busy_after_last", 32'(busy), 32'd0);
                exp_idle = 0;
            end
            if (res_valid && wait_first) begin
                chk("latency", 32'(int'(($time - HALF - t_acc) / PERIOD)), 32'(exp_lat));
                wait_first = 0;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
                    chk("res_last", 32'(res_last), 32'(exp_last_q.pop_front()));
                    if (res_last) exp_idle = 1;
                end
            end
            pv = res_valid;
            pr = res_ready;
            pd = res_data;
        end else begin
            pv = 0;
            pr = 0;
        end
    end

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1;
        end
        chk("op_done", 32'(done), 32'd1);
    endtask

    task automatic run_op(input int n, input logic [31:0] x, y, m, input bit do_wait);
        logic [31:0] e;
        @(posedge clk);
        #1;
        for (int j = 0; j < n; j++) begin
            wr_ena  = 3'b111;
            wr_addr = ADDR_W'(j);
            wr_x    = x[8*j +: 8];
            wr_y    = y[8*j +: 8];
            wr_m    = m[8*j +: 8];
            @(posedge clk);
            #1;
        end
        wr_ena  = 3'b000;
        m1      = calc_m1(m[7:0]);
        n_words = LEN_W'(n);
        e       = mont_ref(n, x, y, m);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back(e[8*j +: 8]);
            exp_last_q.push_back(j == n - 1);
        end
        exp_lat    = n * (2 * n + 3) + n + 1;
        wait_first = 1;
        start      = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        start = 1'b0;
        if (do_wait) wait_done(400);
    endtask

    task automatic err_test(input int nw);
        @(posedge clk);
        #1;
        n_words = LEN_W'(nw);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("err_clear", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
    endtask

    task automatic rand_ops(input int n, output logic [31:0] x, y, m);
        m = $urandom;
        if (n < 4) m = m & ((32'h1 << (8 * n)) - 1);
        m = m | 32'h1;
        x = $urandom % m;
        y = $urandom % m;
    endtask

    initial begin
        logic [31:0] rx, ry, rm;
        rst = 1'b1; wr_ena = '0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_m = '0;
        m1 = '0; n_words = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_last", 32'(res_last), 32'd0);

        // Hand-computed anchors for the model.
        chk("model_m1", 32'(calc_m1(8'hFB)), 32'hCD);
        chk("model_5x7", mont_ref(1, 32'h05, 32'h07, 32'hFB), 32'h07);
        chk("model_rinv", mont_ref(1, 32'hFA, 32'hFA, 32'hFB), 32'hC9);
        run_op(1, 32'h05, 32'h07, 32'hFB, 1);
        run_op(1, 32'hFA, 32'hFA, 32'hFB, 1);

        err_test(0);
        err_test(N_MAX + 1);

        for (int k = 0; k < 500; k++) begin
            ready_full = (k % 2 == 0);
            rand_ops(1 + k % 4, rx, ry, rm);
            run_op(1 + k % 4, rx, ry, rm, 1);
        end
        ready_full = 1;

        // Start while busy must be ignored without an error pulse.
        rand_ops(2, rx, ry, rm);
        run_op(2, rx, ry, rm, 0);
        repeat (3) @(posedge clk);
        #1;
        n_words = LEN_W'(1);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_err", 32'(err), 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_done(400);

        // Reset during the first reduction pass.
        rand_ops(4, rx, ry, rm);
        run_op(4, rx, ry, rm, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        wait_first = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        rand_ops(4, rx, ry, rm);
        run_op(4, rx, ry, rm, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
